// File: rtl/cpx_pkg.sv
// Shared constants, types and helpers for the pipelined complex multiplier.
package cpx_pkg;

  localparam int unsigned CPX_HALF     = 16;
  localparam int unsigned CPX_WORD     = 2 * CPX_HALF;
  localparam int unsigned CPX_FRAC     = 6;
  localparam int unsigned CPX_MULT_LAT = 3;

  typedef logic signed [CPX_HALF-1:0] cpx_comp_t;

  typedef struct packed {
    cpx_comp_t re;
    cpx_comp_t im;
  } cpx_t;

  // Real part occupies the upper half of the packed word.
  function automatic logic [CPX_WORD-1:0] cpx_pack(input cpx_comp_t re, input cpx_comp_t im);
    return {re, im};
  endfunction

  function automatic cpx_t cpx_unpack(input logic [CPX_WORD-1:0] w);
    cpx_t c;
    c.re = w[CPX_WORD-1:CPX_HALF];
    c.im = w[CPX_HALF-1:0];
    return c;
  endfunction

  // Optional round-half-up, then arithmetic shift right by frac.
  function automatic longint cpx_round_shift(input longint x, input int unsigned frac,
                                             input bit rnd);
    longint y;
    y = x;
    if (rnd && (frac > 0)) y = y + (longint'(1) <<< (frac - 1));
    return y >>> frac;
  endfunction

  // Clamp to the representable range of one default-width component.
  function automatic cpx_comp_t cpx_saturate(input longint x);
    longint max_v;
    longint min_v;
    max_v = (longint'(1) <<< (CPX_HALF - 1)) - 1;
    min_v = -(longint'(1) <<< (CPX_HALF - 1));
    if (x > max_v) return cpx_comp_t'(max_v);
    if (x < min_v) return cpx_comp_t'(min_v);
    return cpx_comp_t'(x);
  endfunction

endpackage

// File: rtl/cpx_round_sat.sv
// Combinational round, arithmetic shift and saturate of one product component.
module cpx_round_sat
  import cpx_pkg::*;
#(
  parameter int unsigned HALF  = CPX_HALF,
  parameter int unsigned FRAC  = CPX_FRAC,
  parameter int unsigned ROUND = 1
) (
  input  logic signed [2*HALF+1:0] i_val,
  output logic        [HALF-1:0]   o_res,
  output logic                     o_sat
);

  localparam int unsigned SW       = 2 * HALF + 2;
  localparam int unsigned RndShift = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [SW-1:0] RndInc = ((ROUND != 0) && (FRAC > 0)) ? (SW'(1) << RndShift) : '0;
  localparam logic signed [SW-1:0] MaxV = {{(SW-HALF+1){1'b0}}, {(HALF-1){1'b1}}};
  localparam logic signed [SW-1:0] MinV = {{(SW-HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  logic signed [SW-1:0] w_rnd;
  logic signed [SW-1:0] w_shift;

  // Headroom of two bits above the product sum keeps the rounding add exact.
  always_comb begin
    w_rnd   = i_val + RndInc;
    w_shift = w_rnd >>> FRAC;
    o_sat   = (w_shift > MaxV) || (w_shift < MinV);
    if (w_shift > MaxV) begin
      o_res = MaxV[HALF-1:0];
    end else if (w_shift < MinV) begin
      o_res = MinV[HALF-1:0];
    end else begin
      o_res = w_shift[HALF-1:0];
    end
  end

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage pipelined fixed-point complex multiplier, C = A*B or A*conj(B),
// with valid/ready handshake, rounding, saturation and a sticky overflow flag.
module complex_mult_pipe
  import cpx_pkg::*;
#(
  parameter int unsigned HALF  = CPX_HALF,
  parameter int unsigned WORD  = 2 * HALF,
  parameter int unsigned FRAC  = CPX_FRAC,
  parameter int unsigned ROUND = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_conj,
  input  logic [WORD-1:0] cpx_A,
  input  logic [WORD-1:0] cpx_B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] cpx_C,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int unsigned PW = 2 * HALF + 1;
  localparam int unsigned SW = 2 * HALF + 2;

  // Global stage enable: the whole pipe freezes while the output is held.
  logic w_en;
  assign w_en     = ~(out_valid & ~out_ready);
  assign in_ready = w_en;

  // Stage 1 registers; B.imag carries one extra bit so negating -2^(HALF-1) is exact.
  logic                   r_v1;
  logic signed [HALF-1:0] r_ar, r_ai, r_br;
  logic signed [HALF:0]   r_bi;
  logic signed [HALF:0]   w_bi_ext;
  logic signed [HALF:0]   w_bi_s1;

  assign w_bi_ext = {cpx_B[HALF-1], cpx_B[HALF-1:0]};
  assign w_bi_s1  = in_conj ? -w_bi_ext : w_bi_ext;

  // S1: capture operands, applying the conjugate to B.imag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_v1 <= 1'b0;
      r_ar <= '0;
      r_ai <= '0;
      r_br <= '0;
      r_bi <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_ar <= cpx_A[WORD-1:HALF];
        r_ai <= cpx_A[HALF-1:0];
        r_br <= cpx_B[WORD-1:HALF];
        r_bi <= w_bi_s1;
      end
    end
  end

  // Operands sign-extended to the product width so each multiply is exact.
  logic signed [PW-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x;
  assign w_ar_x = {{(PW-HALF){r_ar[HALF-1]}}, r_ar};
  assign w_ai_x = {{(PW-HALF){r_ai[HALF-1]}}, r_ai};
  assign w_br_x = {{(PW-HALF){r_br[HALF-1]}}, r_br};
  assign w_bi_x = {{(PW-HALF-1){r_bi[HALF]}}, r_bi};

  logic                 r_v2;
  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;

  // S2: the four partial products.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_v2   <= 1'b0;
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p_rr <= w_ar_x * w_br_x;
        r_p_ii <= w_ai_x * w_bi_x;
        r_p_ri <= w_ar_x * w_bi_x;
        r_p_ir <= w_ai_x * w_br_x;
      end
    end
  end

  logic signed [SW-1:0] w_re_sum, w_im_sum;
  assign w_re_sum = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
  assign w_im_sum = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};

  logic [HALF-1:0] w_re_q, w_im_q;
  logic            w_re_sat, w_im_sat;

  cpx_round_sat #(
    .HALF  (HALF),
    .FRAC  (FRAC),
    .ROUND (ROUND)
  ) u_rs_re (
    .i_val (w_re_sum),
    .o_res (w_re_q),
    .o_sat (w_re_sat)
  );

  cpx_round_sat #(
    .HALF  (HALF),
    .FRAC  (FRAC),
    .ROUND (ROUND)
  ) u_rs_im (
    .i_val (w_im_sum),
    .o_res (w_im_q),
    .o_sat (w_im_sat)
  );

  logic            r_v3;
  logic [WORD-1:0] r_c;
  logic            r_ovf;
  logic            w_ovf_set;

  assign w_ovf_set = w_en & r_v2 & (w_re_sat | w_im_sat);

  // S3: output register; data only updates on a valid result so it holds otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_v3 <= 1'b0;
      r_c  <= '0;
    end else if (w_en) begin
      r_v3 <= r_v2;
      if (r_v2) r_c <= {w_re_q, w_im_q};
    end
  end

  // Sticky overflow; a new saturation beats a simultaneous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_valid = r_v3;
  assign cpx_C     = r_c;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed and backpressure bench for complex_mult_pipe with an in-order scoreboard.
module tb_complex_mult_pipe;
  import cpx_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        in_valid;
  logic        in_ready;
  logic        in_conj;
  logic [31:0] cpx_A;
  logic [31:0] cpx_B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] cpx_C;
  logic        ovf;
  logic        ovf_clr;

  int          checks;
  int          failures;
  logic [31:0] sb[$];
  logic        rand_ready;

  complex_mult_pipe dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_conj   (in_conj),
    .cpx_A     (cpx_A),
    .cpx_B     (cpx_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cpx_C     (cpx_C),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent Q9.6 reference: wide integer arithmetic, round-half-up, clamp.
  function automatic logic [15:0] ref_sat(input longint x);
    longint y;
    logic [63:0] bits;
    y = (x + 32) >>> 6;
    if (y > 32767) return 16'h7FFF;
    if (y < -32768) return 16'h8000;
    bits = 64'(y);
    return bits[15:0];
  endfunction

  function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                           input logic cj);
    longint ar, ai, br, bi, re, im;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    if (cj) bi = -bi;
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {ref_sat(re), ref_sat(im)};
  endfunction

  // out_ready driver: random about half the time when enabled, else held high.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: handshake rule, stall stability and in-order result compare.
  initial begin : monitor
    logic        prev_stall;
    logic [31:0] prev_c;
    prev_stall = 1'b0;
    prev_c     = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", cpx_C, prev_c);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_output: observed=%h expected=none", cpx_C);
          end else begin
            check("result", cpx_C, sb.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_c     = cpx_C;
      end
    end
  end

  // Offer one transaction, wait (bounded) for acceptance, queue its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cj,
                      input logic [31:0] exp);
    cpx_A    = a;
    cpx_B    = b;
    in_conj  = cj;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (in_ready) break;
      if (n == 199) check("accept_timeout", 32'(in_ready), 32'd1);
    end
    sb.push_back(exp);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  // Single transaction into an empty pipe with out_ready high; measures latency.
  task automatic send_lat(input logic [31:0] a, input logic [31:0] b, input logic cj,
                          input logic [31:0] exp);
    int lat;
    cpx_A    = a;
    cpx_B    = b;
    in_conj  = cj;
    in_valid = 1'b1;
    @(negedge CLK);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    sb.push_back(exp);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), CPX_MULT_LAT);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rand_ready = 1'b0;
    RST_N      = 1'b0;
    in_valid   = 1'b0;
    in_conj    = 1'b0;
    cpx_A      = '0;
    cpx_B      = '0;
    ovf_clr    = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cpx_C", cpx_C, 32'h0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // (1+2i)(3+4i) = -5+10i ; (1+2i)(3-4i) = 11+2i
    send_lat(cpx_pack(16'h0040, 16'h0080), cpx_pack(16'h00C0, 16'h0100), 1'b0, 32'hFEC0_0280);
    check("basic_ovf", 32'(ovf), 32'd0);
    send_lat(cpx_pack(16'h0040, 16'h0080), cpx_pack(16'h00C0, 16'h0100), 1'b1, 32'h02C0_0080);

    // Half-LSB rounding cases.
    send_lat(cpx_pack(16'h0001, 16'h0000), cpx_pack(16'h0020, 16'h0000), 1'b0, 32'h0001_0000);
    send_lat(cpx_pack(16'hFFFF, 16'h0000), cpx_pack(16'h0020, 16'h0000), 1'b0, 32'h0000_0000);
    check("round_ovf", 32'(ovf), 32'd0);

    // Saturation and sticky flag.
    send_lat(cpx_pack(16'h7FFF, 16'h0000), cpx_pack(16'h7FFF, 16'h0000), 1'b0, 32'h7FFF_0000);
    check("sat_ovf_set", 32'(ovf), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    check("sat_ovf_sticky", 32'(ovf), 32'd1);
    send_lat(cpx_pack(16'h8000, 16'h8000), cpx_pack(16'h8000, 16'h8000), 1'b0, 32'h0000_7FFF);

    ovf_clr = 1'b1;
    @(posedge CLK);
    #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);

    // Saturated result lands on the same edge as a clear: set wins.
    cpx_A    = cpx_pack(16'h7FFF, 16'h0000);
    cpx_B    = cpx_pack(16'h7FFF, 16'h0000);
    in_conj  = 1'b0;
    in_valid = 1'b1;
    sb.push_back(32'h7FFF_0000);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    ovf_clr = 1'b1;
    @(posedge CLK);
    #1;
    ovf_clr = 1'b0;
    check("set_beats_clr_valid", 32'(out_valid), 32'd1);
    check("set_beats_clr_ovf", 32'(ovf), 32'd1);
    @(posedge CLK);
    #1;

    // Back-to-back stream under random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      logic        cj;
      a  = (i % 2 == 0) ? ($urandom() & 32'h01FF_01FF) ^ 32'hFF00_0000 : $urandom();
      b  = (i % 2 == 0) ? ($urandom() & 32'h00FF_00FF) : $urandom();
      cj = 1'($urandom_range(0, 1));
      send(a, b, cj, ref_mult(a, b, cj));
    end
    for (int n = 0; n < 500 && sb.size() != 0; n++) begin
      @(posedge CLK);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    rand_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset with three transactions in flight.
    send_lat(cpx_pack(16'h7FFF, 16'h0000), cpx_pack(16'h7FFF, 16'h0000), 1'b0, 32'h7FFF_0000);
    check("pre_reset_ovf", 32'(ovf), 32'd1);
    send(cpx_pack(16'h0040, 16'h0000), cpx_pack(16'h0040, 16'h0000), 1'b0, 32'h0040_0000);
    send(cpx_pack(16'h0080, 16'h0000), cpx_pack(16'h0040, 16'h0000), 1'b0, 32'h0080_0000);
    send(cpx_pack(16'h00C0, 16'h0000), cpx_pack(16'h0040, 16'h0000), 1'b0, 32'h00C0_0000);
    RST_N = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_cpx_C", cpx_C, 32'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send_lat(cpx_pack(16'h0040, 16'h0080), cpx_pack(16'h00C0, 16'h0100), 1'b0, 32'hFEC0_0280);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
